frame_sequencer: RTL and testbench

//  Front-end controller for the windowing stage. Buffers the incoming 16-bit audio stream
//  in a circular RAM and forms overlapping frames of N samples every HOP samples.

---
 rtl/frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Audio front-end: buffers the sample stream in a circular RAM, cuts overlapping
// N-sample frames every HOP samples, runs them through the window and zero-pads to NF.
module frame_sequencer #(
   parameter int unsigned DW    = 16,
   parameter int unsigned N     = 256,
   parameter int unsigned HOP   = 128,
   parameter int unsigned NF    = 512,
   parameter int unsigned DEPTH = 512
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] audio_in,
   input  logic          audio_valid,
   output logic          win_clr,
   output logic [DW-1:0] win_sample,
   output logic          win_valid,
   input  logic [DW-1:0] win_out,
   input  logic          win_out_valid,
   input  logic          fft_ready,
   output logic [DW-1:0] fft_data,
   output logic          fft_valid,
   output logic          fft_sof,
   output logic          fft_eof,
   output logic [15:0]   ovf_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = $clog2(N + 1);
   localparam int unsigned CW = $clog2(NF + 1);

   typedef enum logic [2:0] {
      S_FILL,
      S_WAIT,
      S_CLR,
      S_FEED,
      S_DRAIN,
      S_PAD
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   start_ptr_q, start_ptr_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic            primed_q, primed_d;
   logic            pending_q, pending_d;
   logic [CW-1:0]   ph_cnt_q, ph_cnt_d;
   logic [FW-1:0]   out_cnt_q, out_cnt_d;
   logic [15:0]     ovf_cnt_q, ovf_cnt_d;
   logic            win_valid_q, win_valid_d;
   logic            due;
   logic            fwd;
   logic            fwd_take;
   logic            pad;
   logic            eof;

   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   rd_data_q;

   // Synchronous-read buffer RAM; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (audio_valid) begin
         mem[wr_ptr_q] <= audio_in;
      end
      rd_data_q <= mem[rd_ptr_q];
   end

   // Write side: the first due needs N samples, every later one HOP more.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      primed_d = primed_q;
      due      = 1'b0;
      if (audio_valid) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if ((!primed_q && fill_q == FW'(N - 1)) || (primed_q && fill_q == FW'(HOP - 1))) begin
            due      = 1'b1;
            fill_d   = '0;
            primed_d = 1'b1;
         end else begin
            fill_d = fill_q + FW'(1);
         end
      end
   end

   // A due frame always points at the newest N samples; an unstarted older one is dropped.
   always_comb begin
      start_ptr_d = start_ptr_q;
      pending_d   = pending_q;
      ovf_cnt_d   = ovf_cnt_q;
      if (state_q == S_CLR) begin
         pending_d = 1'b0;
      end
      if (due) begin
         start_ptr_d = wr_ptr_d - AW'(N);
         pending_d   = 1'b1;
         if (pending_q && state_q != S_CLR && ovf_cnt_q != '1) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      ph_cnt_d    = ph_cnt_q;
      out_cnt_d   = out_cnt_q;
      win_valid_d = 1'b0;
      win_clr     = 1'b0;
      fwd         = 1'b0;
      pad         = 1'b0;
      eof         = 1'b0;
      case (state_q)
         S_FILL: begin
            if (pending_q) begin
               state_d = fft_ready ? S_CLR : S_WAIT;
            end
         end
         S_WAIT: begin
            if (fft_ready) begin
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            win_clr   = 1'b1;
            rd_ptr_d  = start_ptr_q;
            ph_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = S_FEED;
         end
         S_FEED: begin
            win_valid_d = 1'b1;
            fwd         = 1'b1;
            rd_ptr_d    = rd_ptr_q + AW'(1);
            ph_cnt_d    = ph_cnt_q + CW'(1);
            if (ph_cnt_q == CW'(N - 1)) begin
               ph_cnt_d = '0;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            fwd = 1'b1;
            if (win_out_valid && out_cnt_q == FW'(N - 1)) begin
               state_d = S_PAD;
            end
         end
         S_PAD: begin
            pad      = 1'b1;
            ph_cnt_d = ph_cnt_q + CW'(1);
            if (ph_cnt_q == CW'(NF - N - 1)) begin
               eof      = 1'b1;
               ph_cnt_d = '0;
               state_d  = (pending_q && fft_ready) ? S_CLR : S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
      if (fwd && win_out_valid) begin
         out_cnt_d = out_cnt_q + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         start_ptr_q <= '0;
         fill_q      <= '0;
         primed_q    <= 1'b0;
         pending_q   <= 1'b0;
         ph_cnt_q    <= '0;
         out_cnt_q   <= '0;
         ovf_cnt_q   <= '0;
         win_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         start_ptr_q <= start_ptr_d;
         fill_q      <= fill_d;
         primed_q    <= primed_d;
         pending_q   <= pending_d;
         ph_cnt_q    <= ph_cnt_d;
         out_cnt_q   <= out_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
         win_valid_q <= win_valid_d;
      end
   end

   assign fwd_take   = fwd && win_out_valid;
   assign win_valid  = win_valid_q;
   assign win_sample = win_valid_q ? rd_data_q : '0;
   assign fft_valid  = fwd_take || pad;
   assign fft_data   = fwd_take ? win_out : '0;
   assign fft_sof    = fwd_take && (out_cnt_q == '0);
   assign fft_eof    = eof;
   assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a delay-line window model (output = ~input),
// a frame logger, and per-frame checks against hand-derived sample ramps.
module tb_frame_sequencer;

   localparam int DW    = 16;
   localparam int N     = 256;
   localparam int HOP   = 128;
   localparam int NF    = 512;
   localparam int DEPTH = 512;
   localparam int MAXF  = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] audio_in;
   logic          audio_valid;
   logic          win_clr;
   logic [DW-1:0] win_sample;
   logic          win_valid;
   logic [DW-1:0] win_out;
   logic          win_out_valid;
   logic          fft_ready;
   logic [DW-1:0] fft_data;
   logic          fft_valid;
   logic          fft_sof;
   logic          fft_eof;
   logic [15:0]   ovf_cnt;

   always #5 clk = ~clk;

   frame_sequencer #(
      .DW(DW), .N(N), .HOP(HOP), .NF(NF), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .audio_in(audio_in), .audio_valid(audio_valid),
      .win_clr(win_clr), .win_sample(win_sample), .win_valid(win_valid),
      .win_out(win_out), .win_out_valid(win_out_valid),
      .fft_ready(fft_ready),
      .fft_data(fft_data), .fft_valid(fft_valid), .fft_sof(fft_sof), .fft_eof(fft_eof),
      .ovf_cnt(ovf_cnt)
   );

   // Window model: latency picked per frame at win_clr (lat_cfg 0 cycles through 1..8).
   logic [DW-1:0] pd [8];
   logic          pv [8];
   int            lat_cfg;
   int            lat_q;
   int            lat_frame;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
         lat_q     <= 1;
         lat_frame <= 0;
      end else begin
         pd[0] <= ~win_sample;
         pv[0] <= win_valid;
         for (int i = 1; i < 8; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
         end
         if (win_clr) begin
            lat_q     <= (lat_cfg == 0) ? 1 + (lat_frame % 8) : lat_cfg;
            lat_frame <= lat_frame + 1;
         end
      end
   end

   assign win_out       = pd[lat_q-1];
   assign win_out_valid = pv[lat_q-1];

   // Frame logger.
   logic [DW-1:0] win_log [MAXF][N];
   logic [DW-1:0] fft_log [MAXF][NF];
   logic          sof_log [MAXF][NF];
   logic          eof_log [MAXF][NF];
   int            win_n [MAXF];
   int            fft_n [MAXF];
   int            nfr;
   int            cur;
   int            fft_total;
   int            stray;

   initial begin
      nfr = 0; cur = -1; fft_total = 0; stray = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nfr = 0; cur = -1; fft_total = 0; stray = 0;
         end else begin
            if (win_clr) begin
               cur = nfr;
               nfr++;
               if (cur < MAXF) begin
                  win_n[cur] = 0;
                  fft_n[cur] = 0;
               end
            end
            if (win_valid) begin
               if (cur >= 0 && cur < MAXF) begin
                  if (win_n[cur] < N) win_log[cur][win_n[cur]] = win_sample;
                  win_n[cur]++;
               end else stray++;
            end
            if (fft_valid) begin
               fft_total++;
               if (cur >= 0 && cur < MAXF) begin
                  if (fft_n[cur] < NF) begin
                     fft_log[cur][fft_n[cur]] = fft_data;
                     sof_log[cur][fft_n[cur]] = fft_sof;
                     eof_log[cur][fft_n[cur]] = fft_eof;
                  end
                  fft_n[cur]++;
               end else stray++;
            end
            if ((fft_sof || fft_eof) && !fft_valid) stray++;
         end
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v, input int gap);
      audio_in    = 16'(v);
      audio_valid = 1'b1;
      tick();
      audio_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      audio_valid = 1'b0;
      repeat (3) tick();
      check("rst_ctrl", int'({win_clr, win_valid, fft_valid, fft_sof, fft_eof}), 0);
      check("rst_data", int'(win_sample) + int'(fft_data) + int'(ovf_cnt), 0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic check_frame(input int f, input int start);
      int bw = 0;
      int bf = 0;
      int bm = 0;
      logic [DW-1:0] e;
      check($sformatf("f%0d_win_cnt", f), win_n[f], N);
      check($sformatf("f%0d_fft_cnt", f), fft_n[f], NF);
      for (int k = 0; k < N; k++) begin
         e = 16'(start + k);
         if (win_log[f][k] !== e) bw++;
      end
      for (int k = 0; k < NF; k++) begin
         e = (k < N) ? ~16'(start + k) : '0;
         if (fft_log[f][k] !== e) bf++;
         if (sof_log[f][k] !== (k == 0)) bm++;
         if (eof_log[f][k] !== (k == NF - 1)) bm++;
      end
      check($sformatf("f%0d_win_seq_bad", f), bw, 0);
      check($sformatf("f%0d_fft_seq_bad", f), bf, 0);
      check($sformatf("f%0d_sof_eof_bad", f), bm, 0);
   endtask

   typedef struct {
      int n_samples;
      int gap;
      int lat;
      int exp_frames;
      int exp_start0;
      int exp_ovf;
   } scen_t;

   scen_t tbl [3];

   initial begin
      int w;
      rst_n       = 1'b0;
      audio_valid = 1'b0;
      audio_in    = '0;
      fft_ready   = 1'b1;
      lat_cfg     = 1;

      // Ramp value == sample index, so frame f starts at exp_start0 + f*HOP.
      tbl[0] = '{n_samples: 256,  gap: 2, lat: 1, exp_frames: 1,  exp_start0: 0, exp_ovf: 0};
      tbl[1] = '{n_samples: 384,  gap: 2, lat: 8, exp_frames: 2,  exp_start0: 0, exp_ovf: 0};
      tbl[2] = '{n_samples: 2000, gap: 5, lat: 0, exp_frames: 14, exp_start0: 0, exp_ovf: 0};

      for (int s = 0; s < 3; s++) begin
         lat_cfg   = tbl[s].lat;
         fft_ready = 1'b1;
         do_reset();
         for (int i = 0; i < tbl[s].n_samples; i++) send(i, tbl[s].gap);
         repeat (1500) tick();
         check($sformatf("s%0d_frames", s), nfr, tbl[s].exp_frames);
         check($sformatf("s%0d_fft_total", s), fft_total, tbl[s].exp_frames * NF);
         check($sformatf("s%0d_ovf", s), int'(ovf_cnt), tbl[s].exp_ovf);
         check($sformatf("s%0d_stray", s), stray, 0);
         for (int f = 0; f < tbl[s].exp_frames && f < MAXF; f++)
            check_frame(f, tbl[s].exp_start0 + f * HOP);
      end

      // Back-pressure: three dues while blocked, two dropped, newest frame emitted.
      lat_cfg = 4;
      do_reset();
      fft_ready = 1'b0;
      for (int i = 0; i < 512; i++) send(i, 1);
      repeat (20) tick();
      check("wait_frames", nfr, 0);
      check("wait_fft_total", fft_total, 0);
      check("wait_ovf", int'(ovf_cnt), 2);
      fft_ready = 1'b1;
      repeat (1500) tick();
      check("wait_after_frames", nfr, 1);
      check("wait_after_ovf", int'(ovf_cnt), 2);
      check("wait_stray", stray, 0);
      check_frame(0, 256);

      // Reset in the middle of padding.
      lat_cfg = 3;
      do_reset();
      for (int i = 0; i < 256; i++) send(i, 1);
      w = 0;
      while (fft_total < N + 10 && w < 3000) begin
         tick();
         w++;
      end
      check("pad_reached", int'(fft_total >= N + 10), 1);
      rst_n = 1'b0;
      #1;
      check("midpad_rst_ctrl", int'({win_clr, win_valid, fft_valid, fft_sof, fft_eof}), 0);
      check("midpad_rst_data", int'(win_sample) + int'(fft_data) + int'(ovf_cnt), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 255; i++) send(1000 + i, 1);
      repeat (50) tick();
      check("post_rst_frames_n_minus_1", nfr, 0);
      check("post_rst_fft_n_minus_1", fft_total, 0);
      send(1255, 1);
      repeat (1500) tick();
      check("post_rst_frames", nfr, 1);
      check("post_rst_stray", stray, 0);
      check_frame(0, 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
